// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: transfer sequencer for the SPI master.
// Frames one character of char_len bits by counting the clock generator's
// cpol_1 pulses, drives tip/last_clk into the clock generator, wraps the
// character with slave-select setup/hold guard time and pulses done at the end.
//
// Ports:
//   wb_clk_in  wishbone clock (sole clock)
//   wb_rst     synchronous active-high reset
//   go         start request, level, only looked at in IDLE
//   char_len   bits per character (0 means 2**CHAR_LEN_W), latched at start
//   ass        automatic slave select enable
//   ss_sel     slave-select mask (1 = select line)
//   cpol_1     clock generator pulse one cycle before each falling sclk toggle
//   tip        transfer in progress (to clock generator)
//   last_clk   blocks the clock generator's next rising toggle
//   ss_pad_o   slave selects, active-low, registered
//   busy       high in every state except IDLE
//   bit_cnt    bits remaining in the current character
//   done       one-cycle pulse at the end of a transfer
//
// Optional build macro SPI_XFER_IRQ_EN adds ie/irq_ack inputs and a sticky
// irq output that sets on done (when ie=1) and clears on irq_ack.
//
// state | meaning
// IDLE  | waiting for go
// SETUP | SS asserted, waiting SETUP_CYC cycles before tip
// XFER  | tip high, counting cpol_1 pulses down to zero
// HOLD  | SS still asserted for HOLD_CYC cycles after the last falling sclk
// DONE  | one-cycle done pulse, back to IDLE
module spi_xfer_ctrl #(
  parameter int CHAR_LEN_W = 7,
  parameter int SS_NB      = 8,
  parameter int SETUP_CYC  = 2,
  parameter int HOLD_CYC   = 2
) (
  input  logic                  wb_clk_in,
  input  logic                  wb_rst,
  input  logic                  go,
  input  logic [CHAR_LEN_W-1:0] char_len,
  input  logic                  ass,
  input  logic [SS_NB-1:0]      ss_sel,
  input  logic                  cpol_1,
`ifdef SPI_XFER_IRQ_EN
  input  logic                  ie,
  input  logic                  irq_ack,
  output logic                  irq,
`endif
  output logic                  tip,
  output logic                  last_clk,
  output logic [SS_NB-1:0]      ss_pad_o,
  output logic                  busy,
  output logic [CHAR_LEN_W:0]   bit_cnt,
  output logic                  done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_HOLD,
    ST_DONE
  } state_t;

  localparam int SETUP_LD_I = (SETUP_CYC > 0) ? SETUP_CYC - 1 : 0;
  localparam int HOLD_LD_I  = (HOLD_CYC > 0) ? HOLD_CYC - 1 : 0;
  localparam logic [3:0] SETUP_LD = SETUP_LD_I[3:0];
  localparam logic [3:0] HOLD_LD  = HOLD_LD_I[3:0];
  localparam logic [CHAR_LEN_W:0] FULL_LEN = {1'b1, {CHAR_LEN_W{1'b0}}};
  localparam logic [CHAR_LEN_W:0] CNT_ONE  = {{CHAR_LEN_W{1'b0}}, 1'b1};

  state_t                state, state_nxt;
  logic [3:0]            guard_cnt, guard_nxt;
  logic [CHAR_LEN_W:0]   bit_cnt_nxt;
  logic [SS_NB-1:0]      ss_lat, ss_lat_nxt;
  logic [SS_NB-1:0]      ss_nxt;
  logic                  ss_active_nxt;

  // Guard counter is a down-counter loaded with N-1 on entry; the state
  // leaves when it reads zero, giving exactly N cycles of dwell.
  always_comb begin
    state_nxt   = state;
    guard_nxt   = guard_cnt;
    bit_cnt_nxt = bit_cnt;
    ss_lat_nxt  = ss_lat;
    case (state)
      ST_IDLE: begin
        if (go) begin
          bit_cnt_nxt = (char_len == '0) ? FULL_LEN : {1'b0, char_len};
          ss_lat_nxt  = ss_sel;
          if (SETUP_CYC > 0) begin
            state_nxt = ST_SETUP;
            guard_nxt = SETUP_LD;
          end else begin
            state_nxt = ST_XFER;
          end
        end
      end
      ST_SETUP: begin
        if (guard_cnt == 4'd0) state_nxt = ST_XFER;
        else                   guard_nxt = guard_cnt - 4'd1;
      end
      ST_XFER: begin
        // The decrement to zero lands on the clock generator's final falling
        // toggle; last_clk then holds off any further rising edge until tip drops.
        if (bit_cnt == '0) begin
          if (HOLD_CYC > 0) begin
            state_nxt = ST_HOLD;
            guard_nxt = HOLD_LD;
          end else begin
            state_nxt = ST_DONE;
          end
        end else if (cpol_1) begin
          bit_cnt_nxt = bit_cnt - CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (guard_cnt == 4'd0) state_nxt = ST_DONE;
        else                   guard_nxt = guard_cnt - 4'd1;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Slave selects are computed from the next state so the pins move on the
  // same edge as the state register.
  always_comb begin
    ss_active_nxt = (state_nxt == ST_SETUP) || (state_nxt == ST_XFER) ||
                    (state_nxt == ST_HOLD);
    if (ass) ss_nxt = ss_active_nxt ? ~ss_lat_nxt : '1;
    else     ss_nxt = ~ss_sel;
  end

  always_ff @(posedge wb_clk_in) begin
    if (wb_rst) begin
      state     <= ST_IDLE;
      guard_cnt <= 4'd0;
      bit_cnt   <= '0;
      ss_lat    <= '0;
      tip       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ss_pad_o  <= '1;
    end else begin
      state     <= state_nxt;
      guard_cnt <= guard_nxt;
      bit_cnt   <= bit_cnt_nxt;
      ss_lat    <= ss_lat_nxt;
      tip       <= (state_nxt == ST_XFER);
      busy      <= (state_nxt != ST_IDLE);
      done      <= (state_nxt == ST_DONE);
      ss_pad_o  <= ss_nxt;
    end
  end

  assign last_clk = tip & (bit_cnt == '0);

`ifdef SPI_XFER_IRQ_EN
  // Set has priority over acknowledge.
  always_ff @(posedge wb_clk_in) begin
    if (wb_rst)             irq <= 1'b0;
    else if (done && ie)    irq <= 1'b1;
    else if (irq_ack)       irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
module tb_spi_xfer_ctrl;

  logic       wb_clk_in = 1'b0;
  logic       wb_rst;
  logic       go;
  logic [6:0] char_len;
  logic       ass;
  logic [7:0] ss_sel;
  logic       cpol_1;
  logic       tip, last_clk, busy, done;
  logic [7:0] ss_pad_o;
  logic [7:0] bit_cnt;
`ifdef SPI_XFER_IRQ_EN
  logic ie, irq_ack, irq;
`endif

  int n_vec = 0;
  int n_err = 0;

  // clock generator model
  int   div = 1;
  int   cnt = 0;
  logic sclk = 1'b0;
  int   nfall = 0, nrise = 0, ndone = 0;
  int   base_fall = 0, base_rise = 0;
  int   exp_q[$];

  always #5 wb_clk_in = ~wb_clk_in;

  spi_xfer_ctrl #(.CHAR_LEN_W(7), .SS_NB(8), .SETUP_CYC(2), .HOLD_CYC(2)) dut (
    .wb_clk_in (wb_clk_in),
    .wb_rst    (wb_rst),
    .go        (go),
    .char_len  (char_len),
    .ass       (ass),
    .ss_sel    (ss_sel),
    .cpol_1    (cpol_1),
`ifdef SPI_XFER_IRQ_EN
    .ie        (ie),
    .irq_ack   (irq_ack),
    .irq       (irq),
`endif
    .tip       (tip),
    .last_clk  (last_clk),
    .ss_pad_o  (ss_pad_o),
    .busy      (busy),
    .bit_cnt   (bit_cnt),
    .done      (done)
  );

  assign cpol_1 = tip && (cnt == 0) && sclk;

  always @(posedge wb_clk_in) begin
    if (done === 1'b1) ndone <= ndone + 1;
    if (wb_rst) begin
      sclk <= 1'b0;
      cnt  <= div;
    end else if (!tip) begin
      cnt <= div;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
    end else begin
      cnt <= div;
      if (sclk) begin
        sclk  <= 1'b0;
        nfall <= nfall + 1;
      end else if (!last_clk) begin
        sclk  <= 1'b1;
        nrise <= nrise + 1;
      end
    end
  end

  task automatic tick();
    @(negedge wb_clk_in);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic mark_base();
    base_fall = nfall;
    base_rise = nrise;
  endtask

  task automatic test_reset();
    int d0;
    wb_rst = 1'b1; go = 1'b0;
    tick(); tick();
    wb_rst = 1'b0;
    tick();
    n_vec++;
    if ({tip, busy, done, last_clk, ss_pad_o, bit_cnt} !== {4'b0000, 8'hFF, 8'h00}) begin
      n_err++;
      $display("FAIL reset_state: got %h expected %h",
               {tip, busy, done, last_clk, ss_pad_o, bit_cnt}, {4'b0000, 8'hFF, 8'h00});
    end
    div = 1; char_len = 7'd8; ass = 1'b1; ss_sel = 8'h04;
    go = 1'b1; tick(); go = 1'b0;
    for (int i = 0; i < 20 && tip !== 1'b1; i++) tick();
    n_vec++;
    if (tip !== 1'b1) begin n_err++; $display("FAIL rst_tip_rise: got %b expected 1", tip); end
    tick(); tick(); tick();
    d0 = ndone;
    wb_rst = 1'b1; tick(); tick(); wb_rst = 1'b0;
    n_vec++;
    if ({tip, busy, done, last_clk, ss_pad_o, bit_cnt} !== {4'b0000, 8'hFF, 8'h00}) begin
      n_err++;
      $display("FAIL reset_mid_xfer: got %h expected %h",
               {tip, busy, done, last_clk, ss_pad_o, bit_cnt}, {4'b0000, 8'hFF, 8'h00});
    end
    for (int i = 0; i < 6; i++) tick();
    n_vec++;
    if (ndone != d0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_done: done pulses %0d busy %b expected 0 and 0", ndone - d0, busy);
    end
  endtask

  task automatic test_char8();
    bit seen_lc = 1'b0;
    int lc_cycles = 0;
    int f;
    div = 1; char_len = 7'd8; ass = 1'b1; ss_sel = 8'h04;
    mark_base();
    go = 1'b1; exp_q.push_back(8);
    tick(); go = 1'b0;
    n_vec++;
    if ({ss_pad_o, tip, bit_cnt} !== {8'hFB, 1'b0, 8'd8}) begin
      n_err++;
      $display("FAIL c8_setup1: got ss=%h tip=%b cnt=%0d expected ss=fb tip=0 cnt=8", ss_pad_o, tip, bit_cnt);
    end
    tick();
    n_vec++;
    if ({ss_pad_o, tip} !== {8'hFB, 1'b0}) begin
      n_err++;
      $display("FAIL c8_setup2: got ss=%h tip=%b expected ss=fb tip=0", ss_pad_o, tip);
    end
    tick();
    n_vec++;
    if ({ss_pad_o, tip} !== {8'hFB, 1'b1}) begin
      n_err++;
      $display("FAIL c8_tip_rise: got ss=%h tip=%b expected ss=fb tip=1", ss_pad_o, tip);
    end
    for (int i = 0; i < 100 && tip === 1'b1; i++) begin
      tick();
      if (last_clk === 1'b1) begin
        lc_cycles++;
        if (!seen_lc) begin
          seen_lc = 1'b1;
          n_vec++;
          if (nfall - base_fall != 8 || sclk !== 1'b0) begin
            n_err++;
            $display("FAIL c8_lastclk_8th_fall: got falls=%0d sclk=%b expected falls=8 sclk=0",
                     nfall - base_fall, sclk);
          end
        end
      end
    end
    n_vec++;
    if (tip !== 1'b0 || !seen_lc || lc_cycles != 1) begin
      n_err++;
      $display("FAIL c8_tip_fall: got tip=%b lastclk_cycles=%0d expected tip=0 lastclk_cycles=1", tip, lc_cycles);
    end
    n_vec++;
    if ({ss_pad_o, done} !== {8'hFB, 1'b0}) begin
      n_err++;
      $display("FAIL c8_hold1: got ss=%h done=%b expected ss=fb done=0", ss_pad_o, done);
    end
    tick();
    n_vec++;
    if ({ss_pad_o, done} !== {8'hFB, 1'b0}) begin
      n_err++;
      $display("FAIL c8_hold2: got ss=%h done=%b expected ss=fb done=0", ss_pad_o, done);
    end
    tick();
    n_vec++;
    if ({ss_pad_o, done} !== {8'hFF, 1'b1}) begin
      n_err++;
      $display("FAIL c8_ss_release: got ss=%h done=%b expected ss=ff done=1", ss_pad_o, done);
    end
    f = exp_q.pop_front();
    n_vec++;
    if (nfall - base_fall != f || nrise - base_rise != f) begin
      n_err++;
      $display("FAIL c8_edges: got falls=%0d rises=%0d expected %0d each", nfall - base_fall, nrise - base_rise, f);
    end
    tick();
    n_vec++;
    if ({done, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL c8_done_once: got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_len0();
    bit ok;
    int f;
    div = 0; char_len = 7'd0; ass = 1'b1; ss_sel = 8'h01;
    mark_base();
    go = 1'b1; exp_q.push_back(128);
    tick(); go = 1'b0;
    n_vec++;
    if (bit_cnt !== 8'd128) begin n_err++; $display("FAIL len0_load: got %0d expected 128", bit_cnt); end
    wait_done(400, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL len0_done: got timeout expected done"); end
    f = exp_q.pop_front();
    n_vec++;
    if (nfall - base_fall != f || nrise - base_rise != f) begin
      n_err++;
      $display("FAIL len0_edges: got falls=%0d rises=%0d expected %0d each", nfall - base_fall, nrise - base_rise, f);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int f, nd;
    div = 0; char_len = 7'd4; ass = 1'b1; ss_sel = 8'h10;
    mark_base();
    go = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(4);
    for (int i = 0; i < 3; i++) begin
      wait_done(60, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL b2b_done%0d: got timeout expected done", i); end
      f = exp_q.pop_front();
      n_vec++;
      if (nfall - base_fall != f || nrise - base_rise != f) begin
        n_err++;
        $display("FAIL b2b_edges%0d: got falls=%0d rises=%0d expected %0d each", i,
                 nfall - base_fall, nrise - base_rise, f);
      end
      mark_base();
      if (i == 2) go = 1'b0;
      tick();
      n_vec++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle_gap%0d: got busy=%b expected 0", i, busy); end
      tick();
      n_vec++;
      if (busy !== (i < 2)) begin
        n_err++;
        $display("FAIL b2b_restart%0d: got busy=%b expected %b", i, busy, (i < 2));
      end
    end
    // a go pulse while XFER is running must be ignored
    mark_base();
    go = 1'b1; exp_q.push_back(4);
    tick(); go = 1'b0;
    for (int i = 0; i < 20 && tip !== 1'b1; i++) tick();
    tick();
    go = 1'b1; tick(); go = 1'b0;
    wait_done(60, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL gopulse_done: got timeout expected done"); end
    f = exp_q.pop_front();
    n_vec++;
    if (nfall - base_fall != f) begin
      n_err++;
      $display("FAIL gopulse_edges: got falls=%0d expected %0d", nfall - base_fall, f);
    end
    tick();
    nd = ndone;
    for (int i = 0; i < 8; i++) tick();
    n_vec++;
    if (ndone != nd || busy !== 1'b0) begin
      n_err++;
      $display("FAIL gopulse_no_restart: got extra done=%0d busy=%b expected 0 0", ndone - nd, busy);
    end
  endtask

  task automatic test_ass0();
    bit ok;
    int f;
    div = 1; char_len = 7'd8; ass = 1'b0; ss_sel = 8'h01;
    mark_base();
    go = 1'b1; exp_q.push_back(8);
    tick(); go = 1'b0;
    n_vec++;
    if (ss_pad_o !== 8'hFE) begin n_err++; $display("FAIL ass0_start: got %h expected fe", ss_pad_o); end
    for (int i = 0; i < 20 && tip !== 1'b1; i++) tick();
    tick(); tick(); tick();
    ss_sel = 8'h80; char_len = 7'd3;
    n_vec++;
    if (ss_pad_o !== 8'hFE) begin n_err++; $display("FAIL ass0_before: got %h expected fe", ss_pad_o); end
    tick();
    n_vec++;
    if (ss_pad_o !== 8'h7F) begin n_err++; $display("FAIL ass0_follow: got %h expected 7f", ss_pad_o); end
    wait_done(100, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL ass0_done: got timeout expected done"); end
    f = exp_q.pop_front();
    n_vec++;
    if (nfall - base_fall != f) begin
      n_err++;
      $display("FAIL ass0_latched_len: got falls=%0d expected %0d", nfall - base_fall, f);
    end
    tick();
    n_vec++;
    if (ss_pad_o !== 8'h7F) begin n_err++; $display("FAIL ass0_idle: got %h expected 7f", ss_pad_o); end
    ss_sel = 8'h00;
    tick();
    n_vec++;
    if (ss_pad_o !== 8'hFF) begin n_err++; $display("FAIL ass0_clear: got %h expected ff", ss_pad_o); end
    ass = 1'b1;
  endtask

`ifdef SPI_XFER_IRQ_EN
  task automatic test_irq();
    bit ok;
    int f;
    div = 0; char_len = 7'd2; ass = 1'b1; ss_sel = 8'h02; ie = 1'b1; irq_ack = 1'b0;
    for (int t = 0; t < 3; t++) begin
      if (t == 2) ie = 1'b0;
      mark_base();
      go = 1'b1; exp_q.push_back(2);
      tick(); go = 1'b0;
      wait_done(40, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL irq_done%0d: got timeout expected done", t); end
      f = exp_q.pop_front();
      n_vec++;
      if (nfall - base_fall != f) begin
        n_err++;
        $display("FAIL irq_edges%0d: got falls=%0d expected %0d", t, nfall - base_fall, f);
      end
      if (t == 0) begin
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL irq_on_done: got %b expected 0", irq); end
        tick();
        n_vec++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set: got %b expected 1", irq); end
      end else if (t == 1) begin
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        n_vec++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set_wins: got %b expected 1", irq); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL irq_ack_clr: got %b expected 0", irq); end
      end else begin
        tick(); tick();
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL irq_ie0: got %b expected 0", irq); end
      end
      tick();
    end
  endtask
`endif

  initial begin
    wb_rst = 1'b1; go = 1'b0; char_len = 7'd8; ass = 1'b1; ss_sel = 8'h00;
`ifdef SPI_XFER_IRQ_EN
    ie = 1'b0; irq_ack = 1'b0;
`endif
    test_reset();
    test_char8();
    test_len0();
    test_back_to_back();
    test_ass0();
`ifdef SPI_XFER_IRQ_EN
    test_irq();
`endif
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
